// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: shares one synchronous memory port between
// the fetch unit (read-only) and the loader/debug port (read/write). Bad
// accesses are caught before they reach memory, and the loader cannot starve
// fetch for more than MAX_LOAD_BURST consecutive grants.
//
//   owner     | meaning
//   ----------+------------------------------------------------
//   OWN_NONE  | no access was granted last cycle, no response
//   OWN_FETCH | last cycle's grant was fetch; respond to fetch
//   OWN_LOAD  | last cycle's grant was loader; respond to loader

// variables.vh normally provides this; the fallback keeps the file standalone.
`ifndef MEM_BYTES_IMEM
`define MEM_BYTES_IMEM 4096
`endif

module imem_port_arbiter #(
    parameter int unsigned MEM_BYTES      = `MEM_BYTES_IMEM,
    parameter int unsigned MAX_LOAD_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        f_req_valid,
    output logic        f_req_ready,
    input  logic [31:0] f_req_addr,
    output logic        f_rsp_valid,
    output logic [31:0] f_rsp_data,
    output logic        f_rsp_err,

    input  logic        l_req_valid,
    output logic        l_req_ready,
    input  logic        l_req_we,
    input  logic [31:0] l_req_addr,
    input  logic [31:0] l_req_wdata,
    output logic        l_rsp_valid,
    output logic [31:0] l_rsp_data,
    output logic        l_rsp_err,

    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned    CW        = $clog2(MAX_LOAD_BURST + 1);
    localparam logic [CW-1:0]  MAX_CNT   = CW'(MAX_LOAD_BURST);
    localparam logic [31:0]    LAST_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

    owner_t        owner_q, owner_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   f_hold_q, f_hold_d;
    logic [31:0]   l_hold_q, l_hold_d;

    logic          grant_f, grant_l;
    logic [31:0]   sel_addr;
    logic          sel_legal;
    logic [31:0]   rsp_word;

    // Word aligned and inside memory; the unsigned compare also rejects wrap.
    function automatic logic is_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a <= LAST_ADDR);
    endfunction

    // Arbitration: loader wins ties until the starvation counter saturates.
    always_comb begin
        grant_l = 1'b0;
        grant_f = 1'b0;
        if (!rst) begin
            if (l_req_valid && !(f_req_valid && cnt_q == MAX_CNT)) begin
                grant_l = 1'b1;
            end else if (f_req_valid) begin
                grant_f = 1'b1;
            end
        end
    end

    assign sel_addr  = grant_l ? l_req_addr : f_req_addr;
    assign sel_legal = is_legal(sel_addr);
    assign rsp_word  = err_q ? 32'hFFFF_FFFF : mem_read_data;

    // Next-state: owner/err capture, starvation count, issue and hold registers.
    always_comb begin
        owner_d  = OWN_NONE;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        f_hold_d = f_hold_q;
        l_hold_d = l_hold_q;

        if (grant_l) begin
            owner_d = OWN_LOAD;
            err_d   = !sel_legal;
            addr_d  = l_req_addr;
            wdata_d = l_req_wdata;
        end else if (grant_f) begin
            owner_d = OWN_FETCH;
            err_d   = !sel_legal;
            addr_d  = f_req_addr;
            wdata_d = 32'h0;
        end

        if (!f_req_valid || grant_f) begin
            cnt_d = '0;
        end else if (grant_l && cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + CW'(1);
        end

        case (owner_q)
            OWN_FETCH: f_hold_d = rsp_word;
            OWN_LOAD:  l_hold_d = rsp_word;
            default:   ;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            f_hold_q <= 32'h0;
            l_hold_q <= 32'h0;
        end else begin
            owner_q  <= owner_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            f_hold_q <= f_hold_d;
            l_hold_q <= l_hold_d;
        end
    end

    assign f_req_ready = grant_f;
    assign l_req_ready = grant_l;

    // Memory side: granted request drives the port, idle cycles hold the last value.
    always_comb begin
        mem_write_en   = 1'b0;
        mem_addr       = addr_q;
        mem_write_data = wdata_q;
        if (rst) begin
            mem_addr       = 32'h0;
            mem_write_data = 32'h0;
        end else if (grant_l) begin
            mem_write_en   = l_req_we && sel_legal;
            mem_addr       = l_req_addr;
            mem_write_data = l_req_wdata;
        end else if (grant_f) begin
            mem_addr       = f_req_addr;
            mem_write_data = 32'h0;
        end
    end

    // Responses: gated by rst so an in-flight response never escapes a reset.
    always_comb begin
        f_rsp_valid = !rst && (owner_q == OWN_FETCH);
        l_rsp_valid = !rst && (owner_q == OWN_LOAD);
        f_rsp_err   = f_rsp_valid && err_q;
        l_rsp_err   = l_rsp_valid && err_q;
        f_rsp_data  = f_rsp_valid ? rsp_word : f_hold_q;
        l_rsp_data  = l_rsp_valid ? rsp_word : l_hold_q;
    end

endmodule
